// File: rtl/stream_pattern_scanner.sv
// Serial valid/ready scanner: builds a sliding W-bit window and counts matches per frame.
// Build option SCAN_NONOVERLAP_EN: after each hit, W fresh bits must refill the window first.

module detector #(
   parameter int W = 4
) (
   input  logic [W-1:0] window,
   input  logic [W-1:0] pattern,
   output logic         match
);
   assign match = (window == pattern);
endmodule

module stream_pattern_scanner #(
   parameter int W     = 4,
   parameter int LEN_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     pattern_in,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic [W-1:0]     window_o,
   output logic             hit,
   output logic [CNT_W-1:0] match_count,
   output logic             busy,
   output logic             done
);
   localparam int                FILL_W    = $clog2(W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {IDLE, FILL, SCAN, FLUSH, DONE} state_t;

   state_t            state;
   logic [W-1:0]      pattern_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  bit_cnt;
   logic [FILL_W-1:0] fill_cnt;
   logic              eval_pending;
   logic              match;

   logic              accept;
   logic [LEN_W-1:0]  bit_cnt_nxt;
   logic [FILL_W-1:0] fill_cnt_nxt;
   logic              last_bit;
   logic              fill_full;

   detector #(.W(W)) u_detector (
      .window  (window_o),
      .pattern (pattern_q),
      .match   (match)
   );

   assign accept       = bit_valid && bit_ready;
   assign bit_cnt_nxt  = bit_cnt + LEN_W'(1);
   assign fill_cnt_nxt = fill_cnt + FILL_W'(1);
   assign last_bit     = accept && (bit_cnt_nxt == len_q);
   assign fill_full    = (fill_cnt_nxt == FILL_FULL);
   // The compare sees the registered window, so hit trails its completing accept by one cycle.
   assign hit          = eval_pending && match;

   // NOTE: all state here uses non-blocking assignments; where two statements in this block
   // assign the same register in one cycle, the later one wins (start clears override shifts).
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pattern_q    <= '0;
         len_q        <= '0;
         window_o     <= '0;
         bit_cnt      <= '0;
         fill_cnt     <= '0;
         match_count  <= '0;
         eval_pending <= 1'b0;
         bit_ready    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         eval_pending <= 1'b0;
         if (hit && (match_count != CNT_MAX))
            match_count <= match_count + CNT_W'(1);
         if (accept) begin
            window_o <= {window_o[W-2:0], bit_in};
            bit_cnt  <= bit_cnt_nxt;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  pattern_q   <= pattern_in;
                  len_q       <= frame_len;
                  window_o    <= '0;
                  bit_cnt     <= '0;
                  fill_cnt    <= '0;
                  match_count <= '0;
                  busy        <= 1'b1;
                  if (frame_len == '0) begin
                     state <= FLUSH;
                  end else begin
                     state     <= FILL;
                     bit_ready <= 1'b1;
                  end
               end
            end

            FILL: begin
               if (accept) begin
                  fill_cnt <= fill_cnt_nxt;
                  if (fill_full)
                     eval_pending <= 1'b1;
                  // Frame end wins over fill completion.
                  if (last_bit) begin
                     state     <= FLUSH;
                     bit_ready <= 1'b0;
                  end else if (fill_full) begin
                     state <= SCAN;
                  end
               end
            end

            SCAN: begin
`ifdef SCAN_NONOVERLAP_EN
               // A bit accepted alongside the hit is the first bit of the refill.
               if (hit) begin
                  fill_cnt <= FILL_W'(accept);
                  if (last_bit) begin
                     state     <= FLUSH;
                     bit_ready <= 1'b0;
                  end else begin
                     state <= FILL;
                  end
               end else
`endif
               if (accept) begin
                  eval_pending <= 1'b1;
                  if (last_bit) begin
                     state     <= FLUSH;
                     bit_ready <= 1'b0;
                  end
               end
            end

            FLUSH: begin
`ifdef SCAN_NONOVERLAP_EN
               if (hit)
                  fill_cnt <= '0;
`endif
               state <= DONE;
               done  <= 1'b1;
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               bit_ready <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_stream_pattern_scanner.sv
// Directed bench for stream_pattern_scanner; a second instance with CNT_W=2 covers saturation.

module tb_stream_pattern_scanner;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] pattern_in;
   logic [7:0] frame_len;
   logic       bit_in;
   logic       bit_valid;

   logic       bit_ready, hit, busy, done;
   logic [3:0] window_o;
   logic [7:0] match_count;

   logic       s_bit_ready, s_hit, s_busy, s_done;
   logic [3:0] s_window;
   logic [1:0] s_count;

   int checks = 0;
   int errors = 0;

   int          hits, sat_hits, dones, done_at, ready_seen;
   logic [31:0] hit_mask;
   logic [7:0]  count_at_done;
   logic [1:0]  sat_count_at_done;

`ifdef SCAN_NONOVERLAP_EN
   localparam logic [31:0] T1_MASK   = 32'h10;
   localparam logic [31:0] T1_COUNT  = 32'd1;
   localparam logic [31:0] SAT_HITS  = 32'd2;
   localparam logic [31:0] SAT_COUNT = 32'd2;
   localparam logic [31:0] SAT_SCNT  = 32'd2;
`else
   localparam logic [31:0] T1_MASK   = 32'h90;
   localparam logic [31:0] T1_COUNT  = 32'd2;
   localparam logic [31:0] SAT_HITS  = 32'd7;
   localparam logic [31:0] SAT_COUNT = 32'd7;
   localparam logic [31:0] SAT_SCNT  = 32'd3;
`endif

   localparam logic [31:0] T1_STREAM = 32'b1011011;
   localparam logic [31:0] DEBRUIJN  = 32'b0000100110101111000;

   stream_pattern_scanner u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pattern_in  (pattern_in),
      .frame_len   (frame_len),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .bit_ready   (bit_ready),
      .window_o    (window_o),
      .hit         (hit),
      .match_count (match_count),
      .busy        (busy),
      .done        (done)
   );

   stream_pattern_scanner #(.CNT_W(2)) u_sat (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pattern_in  (pattern_in),
      .frame_len   (frame_len),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .bit_ready   (s_bit_ready),
      .window_o    (s_window),
      .hit         (s_hit),
      .match_count (s_count),
      .busy        (s_busy),
      .done        (s_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame; start_at >= 1 pulses a stray start on that cycle of the frame.
   task automatic run_frame(input logic [3:0] pat, input logic [7:0] len, input logic [31:0] stream,
                            input int nbits, input bit gaps, input int start_at);
      int idx;
      int cyc;
      bit ready_now;
      bit got_done;
      hits = 0; sat_hits = 0; dones = 0; done_at = 0; ready_seen = 0;
      hit_mask = '0; count_at_done = '0; sat_count_at_done = '0;
      pattern_in = pat;
      frame_len  = len;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      pattern_in = ~pat;
      frame_len  = 8'd2;
      if (bit_ready) ready_seen++;
      idx = 0;
      cyc = 1;
      got_done = 1'b0;
      while (!got_done && cyc < 300) begin
         bit_valid = (idx < nbits) && (!gaps || (cyc % 2 == 0));
         bit_in    = bit_valid ? stream[nbits-1-idx] : 1'b0;
         start     = (cyc == start_at);
         ready_now = bit_ready;
         tick();
         cyc++;
         if (bit_valid && ready_now) idx++;
         if (bit_ready) ready_seen++;
         if (hit) begin
            hits++;
            hit_mask[idx] = 1'b1;
         end
         if (s_hit) sat_hits++;
         if (done) begin
            got_done          = 1'b1;
            dones++;
            done_at           = cyc;
            count_at_done     = match_count;
            sat_count_at_done = s_count;
         end
      end
      bit_valid = 1'b0;
      start     = 1'b0;
      check("frame_done_seen", 32'(got_done), 32'd1);
      tick();
      if (done) dones++;
   endtask

   initial begin
      bit done_flag;
      rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      pattern_in = '0; frame_len = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy",      32'(busy),        32'd0);
      check("rst_ready",     32'(bit_ready),   32'd0);
      check("rst_hit",       32'(hit),         32'd0);
      check("rst_done",      32'(done),        32'd0);
      check("rst_count",     32'(match_count), 32'd0);
      check("rst_window",    32'(window_o),    32'd0);

      // Main case, gap-free.
      run_frame(4'b1011, 8'd7, T1_STREAM, 7, 1'b0, -1);
      check("t1_hit_mask", hit_mask,               T1_MASK);
      check("t1_count",    32'(count_at_done),     T1_COUNT);
      check("t1_dones",    32'(dones),             32'd1);
      check("t1_done_at",  32'(done_at),           32'd9);
      check("t1_window",   32'(window_o),          32'b1011);
      check("t1_hold",     32'(match_count),       T1_COUNT);
      check("t1_idle",     32'(busy),              32'd0);

      // Same stream with gaps must give the same result.
      run_frame(4'b1011, 8'd7, T1_STREAM, 7, 1'b1, -1);
      check("t1g_hit_mask", hit_mask,              T1_MASK);
      check("t1g_count",    32'(count_at_done),    T1_COUNT);

      // Empty frame.
      run_frame(4'b1011, 8'd0, 32'd0, 0, 1'b0, -1);
      check("len0_done_at", 32'(done_at),          32'd2);
      check("len0_ready",   32'(ready_seen),       32'd0);
      check("len0_count",   32'(count_at_done),    32'd0);
      check("len0_dones",   32'(dones),            32'd1);

      // Frame shorter than W; 0101 is the partial window, so a premature compare would hit.
      run_frame(4'b0101, 8'd3, 32'b101, 3, 1'b0, -1);
      check("len3_hits",    32'(hits),             32'd0);
      check("len3_count",   32'(count_at_done),    32'd0);

      // Backpressure and saturation.
      run_frame(4'b0000, 8'd10, 32'd0, 10, 1'b1, -1);
      check("sat_hits",     32'(hits),             SAT_HITS);
      check("sat_s_hits",   32'(sat_hits),         SAT_HITS);
      check("sat_count",    32'(count_at_done),    SAT_COUNT);
      check("sat_s_count",  32'(sat_count_at_done), SAT_SCNT);

      // Stray start during SCAN is ignored.
      run_frame(4'b1011, 8'd7, T1_STREAM, 7, 1'b0, 6);
      check("stray_hit_mask", hit_mask,            T1_MASK);
      check("stray_count",    32'(count_at_done),  T1_COUNT);
      check("stray_dones",    32'(dones),          32'd1);

      // Reset in the middle of SCAN.
      pattern_in = 4'b1011; frame_len = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bit_valid = 1'b1;
         bit_in    = T1_STREAM[6-i];
         tick();
      end
      bit_valid = 1'b0;
      check("mid_count",  32'(match_count), 32'd1);
      check("mid_window", 32'(window_o),    32'b0110);
      check("mid_busy",   32'(busy),        32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy",   32'(busy),        32'd0);
      check("mrst_ready",  32'(bit_ready),   32'd0);
      check("mrst_count",  32'(match_count), 32'd0);
      check("mrst_window", 32'(window_o),    32'd0);
      check("mrst_done",   32'(done),        32'd0);
      done_flag = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done || busy) done_flag = 1'b1;
      end
      check("mrst_quiet", 32'(done_flag), 32'd0);

      // Every pattern appears exactly once across the de Bruijn frame.
      for (int p = 0; p < 16; p++) begin
         run_frame(4'(p), 8'd19, DEBRUIJN, 19, 1'b0, -1);
         check($sformatf("db_hits_%0d", p),  32'(hits),          32'd1);
         check($sformatf("db_count_%0d", p), 32'(count_at_done), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
